// File: rtl/fifo_word_serializer_pkg.sv
// fifo_word_serializer_pkg
// Definitions shared by the FIFO word serializer and its shift-register
// sub-module. The FSM encoding matches the encoding that the FIFO and its
// bench use (IDLE=0, POP=1, WAIT=2, SHIFT=3), so state values seen in
// waveforms mean the same thing across the buffering stage.
//
// Contents:
//   ser_state_e         serializer FSM state type
//   DEFAULT_DATA_WIDTH  default word width, matching the 32-bit FIFO
//   bit_cnt_width()     width needed to count the bits of one word

package fifo_word_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHIFT = 2'd3
  } ser_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // The counter has to hold the values 0 .. width-1. A 1-bit word still
  // gets a 1-bit counter so that the vector never collapses to zero width.
  function automatic int bit_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fifo_word_serializer_shift_reg.sv
// ser_shift_reg
// Parallel-load shift register for one serial word. It also tracks the bit
// position inside the word and flags the first and last bit positions.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   load       capture load_data and restart the bit counter
//   load_data  parallel word to serialize
//   shift_en   advance by one bit (a bit was accepted downstream)
//   ser_bit    current output bit (MSB or LSB end, selected by MSB_FIRST)
//   first      bit counter is at the first bit of the word
//   last       bit counter is at the last bit of the word

module ser_shift_reg
  import fifo_word_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_en,
  output logic                  ser_bit,
  output logic                  first,
  output logic                  last
);

  localparam int CW = bit_cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;

  // bit_cnt counts down the bits still to send after the current one, so
  // it reads DATA_WIDTH-1 on the first bit and 0 on the last bit. Vacated
  // positions fill with zero; a fully shifted-out register therefore
  // presents 0 on ser_bit.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (load) begin
      shreg_d   = load_data;
      bit_cnt_d = CNT_MAX;
    end else if (shift_en) begin
      if (MSB_FIRST != 0) begin
        shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
      end
      if (bit_cnt_q != '0) begin
        bit_cnt_d = bit_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign ser_bit = (MSB_FIRST != 0) ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
  assign first   = (bit_cnt_q == CNT_MAX);
  assign last    = (bit_cnt_q == '0);

endmodule

// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer
// Downstream consumer of the synchronous FIFO. It pops one word when the
// FIFO has data and is enabled, then sends the word one bit per accepted
// transfer on a valid/ready serial interface.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   enable      permits new pops; sampled only at word boundaries
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after a pop
//   fifo_pop    one-cycle pop strobe to the FIFO
//   ser_ready   downstream accepts the current bit
//   ser_valid   ser_data holds a valid bit
//   ser_data    current serial bit
//   ser_first   marks the first bit of a word
//   ser_last    marks the last bit of a word
//   busy        FSM is not idle
//   word_count  completed words, wraps modulo 2^CNT_WIDTH

module fifo_word_serializer
  import fifo_word_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MSB_FIRST  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  input  logic                  ser_ready,
  output logic                  ser_valid,
  output logic                  ser_data,
  output logic                  ser_first,
  output logic                  ser_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count
);

  ser_state_e           state_q, state_d;
  logic                 fifo_pop_q, fifo_pop_d;
  logic                 busy_q, busy_d;
  logic                 ser_valid_q, ser_valid_d;
  logic [CNT_WIDTH-1:0] word_count_q, word_count_d;

  logic sr_load;
  logic sr_shift;
  logic sr_bit;
  logic sr_first;
  logic sr_last;
  logic word_done;

  // The FIFO presents its data during WAIT, so the capture happens on the
  // edge that leaves WAIT.
  assign sr_load   = (state_q == ST_WAIT);
  assign sr_shift  = ser_valid_q && ser_ready;
  assign word_done = sr_shift && sr_last;

  ser_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_shift_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (sr_load),
    .load_data (fifo_data),
    .shift_en  (sr_shift),
    .ser_bit   (sr_bit),
    .first     (sr_first),
    .last      (sr_last)
  );

  // fifo_empty and enable are looked at only in IDLE and on the edge that
  // accepts the last bit. Those are the only edges that can start a pop,
  // so a pop is never issued into an empty FIFO and a word is never cut
  // short. The output flags are computed from the next state so that they
  // come straight out of flops and line up with the state register.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (word_done) begin
          word_count_d = word_count_q + CNT_WIDTH'(1);
          state_d      = (enable && !fifo_empty) ? ST_POP : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    fifo_pop_d  = (state_d == ST_POP);
    busy_d      = (state_d != ST_IDLE);
    ser_valid_d = (state_d == ST_SHIFT);
  end

  // On reset a word in flight is dropped without being counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fifo_pop_q   <= 1'b0;
      busy_q       <= 1'b0;
      ser_valid_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      fifo_pop_q   <= fifo_pop_d;
      busy_q       <= busy_d;
      ser_valid_q  <= ser_valid_d;
      word_count_q <= word_count_d;
    end
  end

  assign fifo_pop   = fifo_pop_q;
  assign busy       = busy_q;
  assign ser_valid  = ser_valid_q;
  assign ser_data   = sr_bit;
  assign ser_first  = ser_valid_q && sr_first;
  assign ser_last   = ser_valid_q && sr_last;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// tb_fifo_word_serializer
// Self-checking bench for fifo_word_serializer. A small FIFO model feeds an
// MSB-first instance. A second, LSB-first instance is driven by hand.

module tb_fifo_word_serializer;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_pop;
  logic          ser_ready;
  logic          ser_valid;
  logic          ser_data;
  logic          ser_first;
  logic          ser_last;
  logic          busy;
  logic [CW-1:0] word_count;

  logic          enableLsb;
  logic          fifoEmptyLsb;
  logic [DW-1:0] fifoDataLsb;
  logic          fifoPopLsb;
  logic          serReadyLsb;
  logic          serValidLsb;
  logic          serDataLsb;
  logic          serFirstLsb;
  logic          serLastLsb;
  logic          busyLsb;
  logic [CW-1:0] wordCountLsb;

  int checks = 0;
  int errors = 0;

  // FIFO model: storage, pointers and pop bookkeeping
  logic [DW-1:0] fifoMem [0:63];
  int wrPtr = 0;
  int rdPtr = 0;
  int popCount = 0;
  int popEmptyErr = 0;
  int popCountLsb = 0;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  readyPat;
    logic [31:0] expWord;
    logic [15:0] expCount;
  } vec_t;

  vec_t vecs [3];

  fifo_word_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .ser_ready  (ser_ready),
    .ser_valid  (ser_valid),
    .ser_data   (ser_data),
    .ser_first  (ser_first),
    .ser_last   (ser_last),
    .busy       (busy),
    .word_count (word_count)
  );

  fifo_word_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(0), .CNT_WIDTH(CW)) dutLsb (
    .clk        (clk),
    .reset      (reset),
    .enable     (enableLsb),
    .fifo_empty (fifoEmptyLsb),
    .fifo_data  (fifoDataLsb),
    .fifo_pop   (fifoPopLsb),
    .ser_ready  (serReadyLsb),
    .ser_valid  (serValidLsb),
    .ser_data   (serDataLsb),
    .ser_first  (serFirstLsb),
    .ser_last   (serLastLsb),
    .busy       (busyLsb),
    .word_count (wordCountLsb)
  );

  always #5 clk = ~clk;

  // Synchronous FIFO model: data_out becomes valid the cycle after the pop
  assign fifo_empty = (wrPtr == rdPtr);

  always @(posedge clk) begin
    if (fifo_pop) begin
      if (fifo_empty) popEmptyErr++;
      fifo_data <= fifoMem[rdPtr[5:0]];
      rdPtr     <= rdPtr + 1;
      popCount++;
    end
    if (fifoPopLsb) popCountLsb++;
  end

  // Watchdog so that a stuck DUT can never hang the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy);
    enable    = en;
    ser_ready = rdy;
  endtask

  task automatic pushWord(input logic [31:0] w);
    fifoMem[wrPtr[5:0]] = w;
    wrPtr = wrPtr + 1;
  endtask

  // Collect the bits of one word at negedges, cycling ser_ready through
  // readyPat. The task checks the first/last flags on every transfer and
  // checks that the outputs hold while ready is low. It returns at the
  // negedge that presents the last bit, or early once stopAt transfers
  // are done. enable drops when dropEnAt transfers are done.
  task automatic serializeWord(input logic [3:0] readyPat, input int dropEnAt,
                               input int stopAt, output logic [31:0] got,
                               output int nXfer, output int flagErr,
                               output int holdErr);
    logic holdPend;
    logic hData, hFirst, hLast;
    got = '0; nXfer = 0; flagErr = 0; holdErr = 0; holdPend = 1'b0;
    hData = 1'b0; hFirst = 1'b0; hLast = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (nXfer == dropEnAt) enable = 1'b0;
      if (nXfer == stopAt) return;
      ser_ready = readyPat[cyc % 4];
      if (holdPend) begin
        if (!ser_valid || ser_data !== hData || ser_first !== hFirst || ser_last !== hLast)
          holdErr++;
        holdPend = 1'b0;
      end
      if (ser_valid && ser_ready) begin
        got = {got[30:0], ser_data};
        if (ser_first !== (nXfer == 0))  flagErr++;
        if (ser_last  !== (nXfer == 31)) flagErr++;
        nXfer++;
        if (ser_last) return;
      end else if (ser_valid) begin
        holdPend = 1'b1;
        hData = ser_data; hFirst = ser_first; hLast = ser_last;
      end
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] gotLsb;
    int n, fe, he, g, base;

    vecs[0] = '{word: 32'hA5A5A5A5, readyPat: 4'b1001, expWord: 32'hA5A5A5A5, expCount: 16'd2};
    vecs[1] = '{word: 32'hFFFF0000, readyPat: 4'b0101, expWord: 32'hFFFF0000, expCount: 16'd3};
    vecs[2] = '{word: 32'h12345678, readyPat: 4'b1111, expWord: 32'h12345678, expCount: 16'd4};

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    enableLsb = 1'b0; fifoEmptyLsb = 1'b1; fifoDataLsb = 32'h1; serReadyLsb = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset outputs", {fifo_pop, ser_valid, ser_data, ser_first, ser_last, busy}, 0);
    checkOutput("reset word_count", word_count, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle after reset busy", busy, 0);

    // Test 1: word 50 with pop latency checks
    $display("[TB] test 1: single word 0x32");
    pushWord(32'h00000032);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t1 pop cycle", {fifo_pop, busy, ser_valid}, 3'b110);
    @(negedge clk);
    checkOutput("t1 wait cycle", {fifo_pop, busy, ser_valid}, 3'b010);
    @(negedge clk);
    checkOutput("t1 first bit", {ser_valid, ser_first, ser_last, ser_data}, 4'b1100);
    serializeWord(4'b1111, -1, 99, got, n, fe, he);
    checkOutput("t1 word", got, 32'h00000032);
    checkOutput("t1 transfers", n, 32);
    checkOutput("t1 flags", fe, 0);
    @(negedge clk);
    checkOutput("t1 word_count", word_count, 1);
    checkOutput("t1 busy", busy, 0);
    checkOutput("t1 pops", popCount, 1);

    // Table-driven words with different ready patterns
    for (int i = 0; i < 3; i++) begin
      $display("[TB] vector %0d: word 0x%08h", i, vecs[i].word);
      pushWord(vecs[i].word);
      serializeWord(vecs[i].readyPat, -1, 99, got, n, fe, he);
      checkOutput($sformatf("vec%0d word", i), got, vecs[i].expWord);
      checkOutput($sformatf("vec%0d transfers", i), n, 32);
      checkOutput($sformatf("vec%0d flags", i), fe, 0);
      checkOutput($sformatf("vec%0d hold", i), he, 0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d word_count", i), word_count, vecs[i].expCount);
      checkOutput($sformatf("vec%0d busy", i), busy, 0);
    end

    // Test 2: back-to-back words 70 and 90
    $display("[TB] test 2: back-to-back words");
    base = popCount;
    pushWord(32'd70);
    pushWord(32'd90);
    serializeWord(4'b1111, -1, 99, got, n, fe, he);
    checkOutput("t2 word70", got, 32'd70);
    g = 99;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ser_valid) begin
        ser_ready = 1'b0;
        g = c;
        break;
      end
    end
    checkOutput("t2 gap cycles", g, 2);
    serializeWord(4'b1111, -1, 99, got, n, fe, he);
    checkOutput("t2 word90", got, 32'd90);
    repeat (5) @(negedge clk);
    checkOutput("t2 word_count", word_count, 6);
    checkOutput("t2 pops", popCount, base + 2);
    checkOutput("t2 empty busy", {fifo_empty, busy}, 2'b10);

    // Test 4: enable held low, then dropped mid-word
    $display("[TB] test 4: enable control");
    applyStimulus(1'b0, 1'b1);
    pushWord(32'h11111111);
    pushWord(32'h22222222);
    pushWord(32'h33333333);
    repeat (5) @(negedge clk);
    checkOutput("t4 no pop disabled", popCount, 6);
    checkOutput("t4 busy disabled", busy, 0);
    enable = 1'b1;
    serializeWord(4'b1111, 10, 99, got, n, fe, he);
    checkOutput("t4 word", got, 32'h11111111);
    repeat (4) @(negedge clk);
    checkOutput("t4 word_count", word_count, 7);
    checkOutput("t4 remaining", wrPtr - rdPtr, 2);
    checkOutput("t4 pops", popCount, 7);
    checkOutput("t4 busy", busy, 0);

    // Test 5: reset in the middle of a word
    $display("[TB] test 5: reset mid-word");
    enable = 1'b1;
    serializeWord(4'b1111, -1, 16, got, n, fe, he);
    checkOutput("t5 partial transfers", n, 16);
    reset = 1'b1;
    #1;
    checkOutput("t5 outputs in reset",
                {fifo_pop, ser_valid, ser_data, ser_first, ser_last, busy}, 0);
    checkOutput("t5 word_count in reset", word_count, 0);
    @(negedge clk);
    reset = 1'b0;
    serializeWord(4'b1111, -1, 99, got, n, fe, he);
    checkOutput("t5 next word", got, 32'h33333333);
    @(negedge clk);
    checkOutput("t5 word_count", word_count, 1);

    // Test 6: LSB-first instance, word 0x00000001
    $display("[TB] test 6: LSB first");
    enableLsb = 1'b1; fifoEmptyLsb = 1'b0; serReadyLsb = 1'b1;
    @(negedge clk);
    fifoEmptyLsb = 1'b1;
    gotLsb = '0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (serValidLsb && serReadyLsb) begin
        if (n == 0) checkOutput("t6 first bit", {serDataLsb, serFirstLsb}, 2'b11);
        gotLsb[n[4:0]] = serDataLsb;
        n++;
        if (serLastLsb) break;
      end
    end
    checkOutput("t6 word", gotLsb, 32'h00000001);
    checkOutput("t6 transfers", n, 32);
    @(negedge clk);
    checkOutput("t6 word_count", wordCountLsb, 1);
    checkOutput("t6 pops", popCountLsb, 1);
    checkOutput("no pop into empty", popEmptyErr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
